// File: rtl/game_state_ctrl.sv
// rtl/game_state_ctrl.sv - snake game state controller: start, countdown, run, pause, respawn, end.
// One down-counter times COUNTDOWN, RESPAWN and the END_GAME button hold-off.
module game_state_ctrl #(
  parameter int LIVES            = 3,
  parameter int COUNTDOWN_CYCLES = 3,
  parameter int RESPAWN_CYCLES   = 2,
  parameter int END_HOLD_CYCLES  = 4,
  parameter int CNT_W            = 16
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       button,
  input  logic       badCollision,
  input  logic [1:0] gameMode,
  output logic [2:0] state,
  output logic [2:0] lives_left,
  output logic [1:0] mode_latched,
  output logic       restart_pulse,
  output logic       run_en
);

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_RUN       = 3'd2,
    S_PAUSE     = 3'd3,
    S_RESPAWN   = 3'd4,
    S_END       = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CD_LOAD  = CNT_W'(COUNTDOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] RS_LOAD  = CNT_W'(RESPAWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] EH_LOAD  = CNT_W'(END_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       LIVES_INIT = 3'(LIVES);

  state_t           st;
  logic [CNT_W-1:0] timer;
  logic             btn_q;
  logic             end_ready;
  logic             press;
  logic [1:0]       mode_eff;

  assign state    = st;
  assign press    = button & ~btn_q;
  assign mode_eff = (gameMode == 2'b11) ? 2'b01 : gameMode;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      st            <= S_WAIT;
      lives_left    <= 3'd0;
      mode_latched  <= 2'b01;
      restart_pulse <= 1'b0;
      run_en        <= 1'b0;
      timer         <= '0;
      btn_q         <= 1'b1;
      end_ready     <= 1'b0;
    end else begin
      btn_q         <= button;
      restart_pulse <= 1'b0;
      case (st)
        S_WAIT: begin
          if (press) begin
            st            <= S_COUNTDOWN;
            timer         <= CD_LOAD;
            mode_latched  <= mode_eff;
            lives_left    <= (mode_eff == 2'b10) ? 3'd1 : LIVES_INIT;
            restart_pulse <= 1'b1;
          end
        end
        S_COUNTDOWN: begin
          if (timer == '0) begin
            st     <= S_RUN;
            run_en <= 1'b1;
          end else begin
            timer <= timer - CNT_ONE;
          end
        end
        S_RUN: begin
          if (badCollision) begin
            run_en <= 1'b0;
            if (lives_left > 3'd1) begin
              lives_left <= lives_left - 3'd1;
              st         <= S_RESPAWN;
              timer      <= RS_LOAD;
            end else begin
              lives_left <= 3'd0;
              st         <= S_END;
              timer      <= EH_LOAD;
              end_ready  <= 1'b0;
            end
          end else if (press) begin
            st     <= S_PAUSE;
            run_en <= 1'b0;
          end
        end
        S_PAUSE: begin
          if (press) begin
            st     <= S_RUN;
            run_en <= 1'b1;
          end
        end
        S_RESPAWN: begin
          if (timer == '0) begin
            st            <= S_COUNTDOWN;
            timer         <= CD_LOAD;
            restart_pulse <= 1'b1;
          end else begin
            timer <= timer - CNT_ONE;
          end
        end
        S_END: begin
          // The counter reaches zero during the last held-off cycle; presses count from the next one.
          if (end_ready && press) begin
            st        <= S_WAIT;
            end_ready <= 1'b0;
          end else if (timer == '0) begin
            end_ready <= 1'b1;
          end else begin
            timer <= timer - CNT_ONE;
          end
        end
        default: begin
          st        <= S_WAIT;
          run_en    <= 1'b0;
          timer     <= '0;
          end_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
// tb/tb_game_state_ctrl.sv - directed self-checking bench for game_state_ctrl.
module tb_game_state_ctrl;

  logic       clk;
  logic       nrst;
  logic       button;
  logic       badCollision;
  logic [1:0] gameMode;
  logic [2:0] state;
  logic [2:0] lives_left;
  logic [1:0] mode_latched;
  logic       restart_pulse;
  logic       run_en;

  int checks = 0;
  int errors = 0;

  game_state_ctrl dut (
    .clk          (clk),
    .nrst         (nrst),
    .button       (button),
    .badCollision (badCollision),
    .gameMode     (gameMode),
    .state        (state),
    .lives_left   (lives_left),
    .mode_latched (mode_latched),
    .restart_pulse(restart_pulse),
    .run_en       (run_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic [2:0] lv,
                         input logic [1:0] md, input logic rp, input logic re);
    chk({tag, ".state"}, 8'(state), 8'(st));
    chk({tag, ".lives"}, 8'(lives_left), 8'(lv));
    chk({tag, ".mode"}, 8'(mode_latched), 8'(md));
    chk({tag, ".pulse"}, 8'(restart_pulse), 8'(rp));
    chk({tag, ".run_en"}, 8'(run_en), 8'(re));
  endtask

  initial begin
    nrst = 1'b1; button = 1'b0; badCollision = 1'b0; gameMode = 2'b01;
    #2 nrst = 1'b0;
    step(); step();
    chk_all("reset", 3'd0, 3'd0, 2'b01, 1'b0, 1'b0);
    nrst = 1'b1;
    step();
    chk_all("idle", 3'd0, 3'd0, 2'b01, 1'b0, 1'b0);

    // Normal-mode start: one pulse, three countdown cycles, then run
    button = 1'b1;
    step();
    chk_all("start", 3'd1, 3'd3, 2'b01, 1'b1, 1'b0);
    button = 1'b0;
    step(); chk_all("cd2", 3'd1, 3'd3, 2'b01, 1'b0, 1'b0);
    step(); chk_all("cd3", 3'd1, 3'd3, 2'b01, 1'b0, 1'b0);
    step(); chk_all("run", 3'd2, 3'd3, 2'b01, 1'b0, 1'b1);

    // Collision beats a simultaneous press
    badCollision = 1'b1; button = 1'b1;
    step(); chk_all("respawn1", 3'd4, 3'd2, 2'b01, 1'b0, 1'b0);
    badCollision = 1'b0; button = 1'b0;
    step(); chk_all("respawn2", 3'd4, 3'd2, 2'b01, 1'b0, 1'b0);
    step(); chk_all("recd1", 3'd1, 3'd2, 2'b01, 1'b1, 1'b0);
    step(); chk_all("recd2", 3'd1, 3'd2, 2'b01, 1'b0, 1'b0);
    step(); chk_all("recd3", 3'd1, 3'd2, 2'b01, 1'b0, 1'b0);
    step(); chk_all("rerun", 3'd2, 3'd2, 2'b01, 1'b0, 1'b1);

    // Held button pauses once; collisions ignored while paused
    button = 1'b1;
    step(); chk_all("pause", 3'd3, 3'd2, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      badCollision = (i >= 4);
      step();
      chk("pause_hold.state", 8'(state), 8'd3);
    end
    chk("pause_hold.lives", 8'(lives_left), 8'd2);
    button = 1'b0;
    step(); chk("pause_rel.state", 8'(state), 8'd3);
    badCollision = 1'b0; button = 1'b1;
    step(); chk_all("resume", 3'd2, 3'd2, 2'b01, 1'b0, 1'b1);
    button = 1'b0;
    step();

    // Asynchronous reset mid-run
    nrst = 1'b0;
    #1;
    chk_all("async_rst", 3'd0, 3'd0, 2'b01, 1'b0, 1'b0);
    button = 1'b1;
    step(); step();
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("held_thru_rst.state", 8'(state), 8'd0);
      chk("held_thru_rst.pulse", 8'(restart_pulse), 8'd0);
    end
    button = 1'b0;
    step(); chk("released.state", 8'(state), 8'd0);

    // Wall-spawn start: single life
    gameMode = 2'b10; button = 1'b1;
    step(); chk_all("ws_start", 3'd1, 3'd1, 2'b10, 1'b1, 1'b0);
    button = 1'b0;
    step(); step();
    step(); chk_all("ws_run", 3'd2, 3'd1, 2'b10, 1'b0, 1'b1);
    badCollision = 1'b1;
    step(); chk_all("end", 3'd5, 3'd0, 2'b10, 1'b0, 1'b0);
    badCollision = 1'b0;

    // Presses in hold-off cycles 1 and 3 ignored; press in cycle 5 returns to WAIT
    button = 1'b1; step(); chk("end_c1", 8'(state), 8'd5);
    button = 1'b0; step(); chk("end_c2", 8'(state), 8'd5);
    button = 1'b1; step(); chk("end_c3", 8'(state), 8'd5);
    button = 1'b0; step(); chk("end_c4", 8'(state), 8'd5);
    button = 1'b1; step(); chk_all("end_exit", 3'd0, 3'd0, 2'b10, 1'b0, 1'b0);
    button = 1'b0;
    step(); chk("wait_hold.mode", 8'(mode_latched), 8'h2);

    // Mode 11 latches as NORMAL with full lives
    gameMode = 2'b11; button = 1'b1;
    step(); chk_all("m11_start", 3'd1, 3'd3, 2'b01, 1'b1, 1'b0);
    button = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 SHALL have parameter LIVES, default 3: lives per game, range 1..7.
REQ-002 SHALL have parameter COUNTDOWN_CYCLES, default 3: cycles spent in COUNTDOWN, >=1.
REQ-003 SHALL have parameter RESPAWN_CYCLES, default 2: cycles spent in RESPAWN, >=1.
REQ-004 SHALL have parameter END_HOLD_CYCLES, default 4: cycles in END_GAME during which the button is ignored, >=1.
REQ-005 SHALL have parameter CNT_W, default 16: width of the internal timer, wide enough for every cycle parameter.
REQ-006 SHALL have port clk, input, 1: the single clock; all state changes occur on its rising edge.
REQ-007 SHALL have port nrst, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port button, input, 1: synchronous level from the player button.
REQ-009 SHALL have port badCollision, input, 1: synchronous level, high when the snake hits itself or a wall.
REQ-010 SHALL have port gameMode, input, 2: 00 TWO_APPLE, 01 NORMAL, 10 WALL_SPAWN, 11 treated as NORMAL.
REQ-011 SHALL have port state, output, 3: registered state code.
REQ-012 SHALL have port lives_left, output, 3: remaining lives.
REQ-013 SHALL have port mode_latched, output, 2: game mode captured at game start.
REQ-014 SHALL have port restart_pulse, output, 1: one-cycle pulse to clear snake/apple logic.
REQ-015 SHALL have port run_en, output, 1: high exactly while state is RUN.

Function
REQ-016 SHALL encode states WAIT=0, COUNTDOWN=1, RUN=2, PAUSE=3, RESPAWN=4, END_GAME=5; codes 6 and 7 SHALL go to WAIT on the next edge.
REQ-017 SHALL detect a button press as a rising edge (button high this cycle, low last cycle); a held button SHALL count as one press.
REQ-018 In WAIT, a press SHALL go to COUNTDOWN, latch gameMode (11 latched as 01), load lives_left (1 if the latched mode is WALL_SPAWN, else LIVES), and assert restart_pulse for that one edge.
REQ-019 COUNTDOWN SHALL last exactly COUNTDOWN_CYCLES cycles, then go to RUN; presses and collisions SHALL be ignored.
REQ-020 In RUN, badCollision high SHALL take priority over a press.
REQ-021 In RUN, on a collision with lives_left > 1, the block SHALL decrement lives_left and go to RESPAWN.
REQ-022 In RUN, on a collision with lives_left == 1, the block SHALL set lives_left to 0 and go to END_GAME.
REQ-023 In RUN, a press with no collision SHALL go to PAUSE.
REQ-024 In PAUSE, a press SHALL go to RUN; badCollision SHALL be ignored.
REQ-025 RESPAWN SHALL last exactly RESPAWN_CYCLES cycles, then go to COUNTDOWN; restart_pulse SHALL assert on the RESPAWN->COUNTDOWN edge; presses SHALL be ignored.
REQ-026 In END_GAME, presses SHALL be ignored for the first END_HOLD_CYCLES cycles; after that, a press SHALL go to WAIT.
REQ-027 SHALL use one down-counter of CNT_W bits, loaded with (N-1) on entry to each timed state and decremented each cycle; the exit/enable condition SHALL be counter==0; the counter SHALL never wrap.
REQ-028 lives_left and mode_latched SHALL hold their values outside the transitions that update them.
REQ-029 All outputs SHALL be registered or decoded only from registered state; no input-to-output combinational path.

Reset
REQ-030 nrst low SHALL immediately force: state=WAIT, lives_left=0, mode_latched=01, restart_pulse=0, run_en=0, timer=0, button-edge history=1 (so a button held through reset is not a press).
REQ-031 A reset asserted mid-game (any state) SHALL abort the game with no further pulses; after release, the block SHALL wait for a fresh press.

Verification
REQ-032 Defaults; reset; press in WAIT with gameMode=01 -> restart_pulse for 1 cycle, COUNTDOWN for exactly 3 cycles, then RUN, lives_left=3, run_en=1.
REQ-033 In RUN, collision and press in the same cycle with lives_left=3 -> RESPAWN, lives_left=2, 2 cycles later COUNTDOWN with restart_pulse, then RUN.
REQ-034 gameMode=10 start; collision in RUN -> END_GAME, lives_left=0; presses in the first 4 cycles ignored; 5th-cycle press -> WAIT.
REQ-035 Button held high for 10 cycles in RUN -> single transition to PAUSE; collision in PAUSE -> stays PAUSE; next press -> RUN.
REQ-036 Button held through reset release -> stays WAIT until released and pressed again; reset asserted in RUN -> WAIT with all outputs at reset values asynchronously.
REQ-037 gameMode=11 at start -> mode_latched=01, lives_left=3.
